// File: rtl/icache_dm_refill_pkg.sv
// icache_pkg: shared types and helpers for the direct-mapped instruction cache.
//   state_e    : refill FSM states
//   off_w()    : word-offset width for a given line size
//   tag_w()    : tag width for a given address/index/line geometry
//   addr_field : extract a bit field from a byte address
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      RESP   = 2'd2
   } state_e;

   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int tag_w(input int addr_w, input int idx_w, input int line_words);
      return addr_w - 2 - off_w(line_words) - idx_w;
   endfunction

   // Field of `width` bits starting at bit `lsb`, zero-extended.
   function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb,
                                              input int width);
      return (addr >> lsb) & ((64'd1 << width) - 64'd1);
   endfunction

endpackage

// File: rtl/icache_dm_refill_stats.sv
// icache_stats: hit/miss statistics, two saturating counters.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_hit_inc      : count one hit at this edge
//   i_miss_inc     : count one miss at this edge
//   o_hit_cnt      : saturating hit count
//   o_miss_cnt     : saturating miss count
module icache_stats #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_hit_inc,
   input  logic             i_miss_inc,
   output logic [CNT_W-1:0] o_hit_cnt,
   output logic [CNT_W-1:0] o_miss_cnt
);

   logic [CNT_W-1:0] r_hit;
   logic [CNT_W-1:0] r_miss;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hit  <= '0;
         r_miss <= '0;
      end else begin
         // Hold at all-ones instead of wrapping.
         if (i_hit_inc && (r_hit != '1))
            r_hit <= r_hit + CNT_W'(1);
         if (i_miss_inc && (r_miss != '1))
            r_miss <= r_miss + CNT_W'(1);
      end
   end

   assign o_hit_cnt  = r_hit;
   assign o_miss_cnt = r_miss;

endmodule

// File: rtl/icache_dm_refill.sv
// icache_dm_refill: direct-mapped instruction cache with multi-word lines and
// an autonomous line-refill engine.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_cpu_req/i_cpu_addr: fetch request (held until o_cpu_ready), byte address
//   o_cpu_ready         : requested word valid this cycle (hits are same-cycle)
//   o_cpu_rdata         : fetched word, 0 when not ready
//   i_flush             : single-cycle pulse, invalidate every line
//   o_mem_req/o_mem_addr: memory word request and word-aligned byte address
//   i_mem_ack/i_mem_rdata: memory completes the current word
//   o_hit_cnt/o_miss_cnt: saturating statistics
module icache_dm_refill
   import icache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int IDX_W      = 4,
   parameter int LINE_WORDS = 4,
   parameter int CNT_W      = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cpu_req,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   output logic              o_cpu_ready,
   output logic [31:0]       o_cpu_rdata,
   input  logic              i_flush,
   output logic              o_mem_req,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_ack,
   input  logic [31:0]       i_mem_rdata,
   output logic [CNT_W-1:0]  o_hit_cnt,
   output logic [CNT_W-1:0]  o_miss_cnt
);

   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int TAG_W = tag_w(ADDR_W, IDX_W, LINE_WORDS);
   localparam int LINES = 1 << IDX_W;

   // Line storage; only the valid bits are reset.
   logic [LINES-1:0] r_valid;
   logic [TAG_W-1:0] r_tag  [LINES];
   logic [31:0]      r_data [LINES][LINE_WORDS];

   // Refill context, latched at the miss.
   state_e           r_state;
   logic [31:0]      r_buf  [LINE_WORDS];
   logic [OFF_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [TAG_W-1:0] r_tagl;
   logic [OFF_W-1:0] r_off;
   logic             r_flush_pend;
   logic             r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;

   logic [OFF_W-1:0]  w_off;
   logic [IDX_W-1:0]  w_idx;
   logic [TAG_W-1:0]  w_tag;
   logic [ADDR_W-1:0] w_base;
   logic              w_hit;
   logic              w_miss;
   logic              w_last;

   assign w_off  = OFF_W'(addr_field(64'(i_cpu_addr), 2, OFF_W));
   assign w_idx  = IDX_W'(addr_field(64'(i_cpu_addr), 2 + OFF_W, IDX_W));
   assign w_tag  = TAG_W'(addr_field(64'(i_cpu_addr), 2 + OFF_W + IDX_W, TAG_W));
   assign w_base = i_cpu_addr & ~ADDR_W'(LINE_WORDS * 4 - 1);

   // Lookups are only honoured in IDLE; during a refill the request is
   // already owned by the engine.
   assign w_hit  = (r_state == IDLE) && i_cpu_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_miss = (r_state == IDLE) && i_cpu_req && !w_hit;
   assign w_last = (r_cnt == OFF_W'(LINE_WORDS - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_valid      <= '0;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_tagl       <= '0;
         r_off        <= '0;
         r_flush_pend <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // The hit (if any) is served from the pre-flush contents.
               if (i_flush)
                  r_valid <= '0;
               if (w_miss) begin
                  r_state    <= REFILL;
                  r_cnt      <= '0;
                  r_idx      <= w_idx;
                  r_tagl     <= w_tag;
                  r_off      <= w_off;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= w_base;
               end
            end
            REFILL: begin
               if (i_flush)
                  r_flush_pend <= 1'b1;
               if (i_mem_ack) begin
                  r_cnt <= r_cnt + OFF_W'(1);
                  if (w_last) begin
                     r_state   <= RESP;
                     r_mem_req <= 1'b0;
                  end else begin
                     r_mem_addr <= r_mem_addr + ADDR_W'(4);
                  end
               end
            end
            RESP: begin
               // A flush seen at any point of the refill also kills the
               // line being installed now.
               if (i_flush || r_flush_pend)
                  r_valid <= '0;
               else
                  r_valid[r_idx] <= 1'b1;
               r_flush_pend <= 1'b0;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Line buffer fill; ack outside REFILL is ignored.
   always_ff @(posedge i_clk) begin
      if ((r_state == REFILL) && i_mem_ack)
         r_buf[r_cnt] <= i_mem_rdata;
   end

   // Install the completed line.
   always_ff @(posedge i_clk) begin
      if (r_state == RESP) begin
         r_tag[r_idx] <= r_tagl;
         for (int w = 0; w < LINE_WORDS; w++)
            r_data[r_idx][w] <= r_buf[w];
      end
   end

   always_comb begin
      o_cpu_ready = 1'b0;
      o_cpu_rdata = '0;
      if (w_hit) begin
         o_cpu_ready = 1'b1;
         o_cpu_rdata = r_data[w_idx][w_off];
      end else if (r_state == RESP) begin
         o_cpu_ready = 1'b1;
         o_cpu_rdata = r_buf[r_off];
      end
   end

   assign o_mem_req  = r_mem_req;
   assign o_mem_addr = r_mem_addr;

   icache_stats #(
      .CNT_W (CNT_W)
   ) u_stats (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_hit_inc  (w_hit),
      .i_miss_inc (w_miss),
      .o_hit_cnt  (o_hit_cnt),
      .o_miss_cnt (o_miss_cnt)
   );

endmodule

// File: tb/tb_icache_dm_refill.sv
// Bench for icache_dm_refill: directed scenarios plus a randomized run,
// checked against a line-level cache model (16 lines x 16 bytes).
module tb_icache_dm_refill;

   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cpu_req = 1'b0;
   logic [31:0]       cpu_addr = '0;
   logic              flush = 1'b0;
   logic              mem_ack = 1'b0;
   logic [31:0]       mem_rdata = '0;
   logic              cpu_ready;
   logic [31:0]       cpu_rdata;
   logic              mem_req;
   logic [31:0]       mem_addr;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   int total = 0;
   int bad   = 0;
   int wait_cyc = 0;
   int wcnt = 0;
   logic [31:0] mlog[$];

   // Model state
   bit mv[16];
   int mt[16];
   int m_hit = 0;
   int m_miss = 0;

   always #5 clk = ~clk;

   icache_dm_refill #(
      .ADDR_W(32), .IDX_W(4), .LINE_WORDS(4), .CNT_W(CNT_W)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr),
      .o_cpu_ready(cpu_ready), .o_cpu_rdata(cpu_rdata), .i_flush(flush),
      .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack),
      .i_mem_rdata(mem_rdata), .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Memory: acks after wait_cyc idle cycles per word; random junk on ack
   // while no request is outstanding.
   always @(negedge clk) begin
      if (mem_req && wcnt >= wait_cyc) begin
         mem_ack   = 1'b1;
         mem_rdata = memf(mem_addr);
         wcnt      = 0;
      end else begin
         mem_ack   = mem_req ? 1'b0 : 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         if (mem_req) wcnt++;
         else wcnt = 0;
      end
   end

   function automatic int miss_lat();
      return 4 * (wait_cyc + 1) + 1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mv[i] = 0;
   endtask

   // Returns whether the access hits, and applies its effect on the model.
   task automatic model_access(input logic [31:0] a, input int flush_at, output bit h);
      int i, t;
      i = int'((a >> 4) & 32'hF);
      t = int'(a >> 8);
      h = mv[i] && (mt[i] == t);
      if (h) begin
         m_hit++;
         if (flush_at == 0) model_clear();
      end else begin
         m_miss++;
         if (flush_at == 0) model_clear();
         mv[i] = 1;
         mt[i] = t;
         if (flush_at >= 1 && flush_at <= miss_lat()) model_clear();
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1; cpu_req = 1'b0; flush = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      model_clear();
      m_hit = 0;
      m_miss = 0;
   endtask

   // Issues one fetch; lat counts cycles from the request cycle to ready.
   task automatic do_read(input logic [31:0] a, input int flush_at,
                          output int lat, output logic [31:0] data);
      lat = 0;
      data = '0;
      mlog.delete();
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_addr = a; flush = (flush_at == 0);
      forever begin
         #1;
         if (mem_req) mlog.push_back(mem_addr);
         if (cpu_ready) begin
            data = cpu_rdata;
            break;
         end
         if (lat >= 200) begin
            total++; bad++;
            $display("FAIL timeout addr=%h no cpu_ready within 200 cycles", a);
            break;
         end
         @(posedge clk); #1;
         lat++;
         flush = (lat == flush_at);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", cpu_ready); end
      total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", cpu_rdata); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
      total++; if (hit_cnt !== 4'd0) begin bad++; $display("FAIL rst_hit got=%0d exp=0", hit_cnt); end
      total++; if (miss_cnt !== 4'd0) begin bad++; $display("FAIL rst_miss got=%0d exp=0", miss_cnt); end
      @(posedge clk); #1 rst = 1'b0;
      model_clear();
   endtask

   task automatic test_basic_miss_hit();
      int lat; logic [31:0] d; bit h;
      model_access(32'h40, -1, h);
      do_read(32'h40, -1, lat, d);
      total++; if (h || lat != 5) begin bad++; $display("FAIL miss_latency got=%0d exp=5", lat); end
      total++; if (d !== 32'hA5A5_0040) begin bad++; $display("FAIL miss_data got=%h exp=A5A50040", d); end
      total++;
      if (mlog.size() != 4) begin bad++; $display("FAIL miss_addr_count got=%0d exp=4", mlog.size()); end
      else for (int k = 0; k < 4; k++)
         if (mlog[k] !== 32'h40 + 32'(4 * k)) begin
            bad++; $display("FAIL miss_addr_seq[%0d] got=%h exp=%h", k, mlog[k], 32'h40 + 32'(4 * k)); break;
         end
      total++; if (miss_cnt !== 4'd1) begin bad++; $display("FAIL miss_cnt got=%0d exp=1", miss_cnt); end
      #1;
      total++; if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin
         bad++; $display("FAIL idle_out got=%b/%h exp=0/0", cpu_ready, cpu_rdata); end
      model_access(32'h48, -1, h);
      do_read(32'h48, -1, lat, d);
      total++; if (!h || lat != 0) begin bad++; $display("FAIL hit_latency got=%0d exp=0", lat); end
      total++; if (d !== 32'hA5A5_0048) begin bad++; $display("FAIL hit_data got=%h exp=A5A50048", d); end
      total++; if (hit_cnt !== 4'd1) begin bad++; $display("FAIL hit_cnt got=%0d exp=1", hit_cnt); end
   endtask

   task automatic test_evict();
      int lat; logic [31:0] d; bit h;
      model_access(32'h440, -1, h);
      do_read(32'h440, -1, lat, d);
      total++; if (lat != 5) begin bad++; $display("FAIL evict_fill_lat got=%0d exp=5", lat); end
      total++; if (d !== 32'hA5A5_0440) begin bad++; $display("FAIL evict_fill_data got=%h exp=A5A50440", d); end
      model_access(32'h40, -1, h);
      do_read(32'h40, -1, lat, d);
      total++; if (lat != 5) begin bad++; $display("FAIL evict_remiss_lat got=%0d exp=5", lat); end
      total++; if (miss_cnt !== 4'd3) begin bad++; $display("FAIL evict_miss_cnt got=%0d exp=3", miss_cnt); end
   endtask

   task automatic test_wait_states();
      int lat; logic [31:0] d; bit h;
      wait_cyc = 2;
      model_access(32'h84, -1, h);
      do_read(32'h84, -1, lat, d);
      total++; if (lat != 13) begin bad++; $display("FAIL wait_latency got=%0d exp=13", lat); end
      total++; if (d !== 32'hA5A5_0084) begin bad++; $display("FAIL wait_data got=%h exp=A5A50084", d); end
      total++;
      if (mlog.size() != 12) begin bad++; $display("FAIL wait_req_cycles got=%0d exp=12", mlog.size()); end
      else for (int k = 0; k < 12; k++)
         if (mlog[k] !== 32'h80 + 32'(4 * (k / 3))) begin
            bad++; $display("FAIL wait_addr_hold[%0d] got=%h exp=%h", k, mlog[k], 32'h80 + 32'(4 * (k / 3))); break;
         end
      wait_cyc = 0;
   endtask

   task automatic test_flush();
      int lat; logic [31:0] d; bit h;
      model_access(32'hC0, 2, h);
      do_read(32'hC0, 2, lat, d);
      total++; if (lat != 5 || d !== 32'hA5A5_00C0) begin
         bad++; $display("FAIL flush_refill_deliver got=%0d/%h exp=5/A5A500C0", lat, d); end
      model_access(32'hC0, -1, h);
      do_read(32'hC0, -1, lat, d);
      total++; if (lat != 5) begin bad++; $display("FAIL flush_refill_remiss got=%0d exp=5", lat); end
      model_access(32'hC4, 0, h);
      do_read(32'hC4, 0, lat, d);
      total++; if (lat != 0 || d !== 32'hA5A5_00C4) begin
         bad++; $display("FAIL flush_idle_hit got=%0d/%h exp=0/A5A500C4", lat, d); end
      model_access(32'hC0, -1, h);
      do_read(32'hC0, -1, lat, d);
      total++; if (lat != 5) begin bad++; $display("FAIL flush_idle_remiss got=%0d exp=5", lat); end
   endtask

   task automatic test_rst_mid_refill();
      int lat; logic [31:0] d; bit h;
      do_reset();
      model_access(32'h40, -1, h);
      do_read(32'h40, -1, lat, d);
      @(posedge clk); #1 cpu_req = 1'b1; cpu_addr = 32'h100;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b1;
      #1;
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
         bad++; $display("FAIL rstmid_second_word got=%b/%h exp=1/00000104", mem_req, mem_addr); end
      @(posedge clk); #1 rst = 1'b0; cpu_req = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
         bad++; $display("FAIL rstmid_idle got=%b/%b exp=0/0", mem_req, cpu_ready); end
      model_clear(); m_hit = 0; m_miss = 0;
      model_access(32'h100, -1, h);
      do_read(32'h100, -1, lat, d);
      total++; if (lat != 5 || d !== 32'hA5A5_0100) begin
         bad++; $display("FAIL rstmid_line_miss got=%0d/%h exp=5/A5A50100", lat, d); end
      model_access(32'h40, -1, h);
      do_read(32'h40, -1, lat, d);
      total++; if (lat != 5) begin bad++; $display("FAIL rstmid_other_invalid got=%0d exp=5", lat); end
      total++; if (miss_cnt !== 4'd2) begin bad++; $display("FAIL rstmid_miss_cnt got=%0d exp=2", miss_cnt); end
   endtask

   task automatic test_saturation();
      int lat; logic [31:0] d; bit h;
      do_reset();
      model_access(32'h200, -1, h);
      do_read(32'h200, -1, lat, d);
      for (int k = 0; k < 20; k++) begin
         model_access(32'h200 + 32'(4 * (k % 4)), -1, h);
         do_read(32'h200 + 32'(4 * (k % 4)), -1, lat, d);
      end
      total++; if (hit_cnt !== 4'(CMAX)) begin bad++; $display("FAIL sat_hit got=%0d exp=%0d", hit_cnt, CMAX); end
      total++; if (miss_cnt !== 4'd1) begin bad++; $display("FAIL sat_miss got=%0d exp=1", miss_cnt); end
   endtask

   task automatic test_random();
      int lat, fa, exp_lat; logic [31:0] a, d; bit h;
      do_reset();
      for (int n = 0; n < 80; n++) begin
         wait_cyc = $urandom_range(0, 2);
         a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
             (32'($urandom_range(0, 3)) << 2);
         fa = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 3)) : -1;
         model_access(a, fa, h);
         exp_lat = h ? 0 : miss_lat();
         do_read(a, fa, lat, d);
         total++; if (lat != exp_lat || d !== memf(a)) begin
            bad++; $display("FAIL rand[%0d] addr=%h got=%0d/%h exp=%0d/%h", n, a, lat, d, exp_lat, memf(a)); end
      end
      wait_cyc = 0;
      total++; if (hit_cnt !== 4'((m_hit > CMAX) ? CMAX : m_hit)) begin
         bad++; $display("FAIL rand_hit_cnt got=%0d exp=%0d", hit_cnt, (m_hit > CMAX) ? CMAX : m_hit); end
      total++; if (miss_cnt !== 4'((m_miss > CMAX) ? CMAX : m_miss)) begin
         bad++; $display("FAIL rand_miss_cnt got=%0d exp=%0d", miss_cnt, (m_miss > CMAX) ? CMAX : m_miss); end
   endtask

   initial begin
      test_reset();
      test_basic_miss_hit();
      test_evict();
      test_wait_states();
      test_flush();
      test_rst_mid_refill();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
